// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 4;
  // Wide enough to hold any legal latency value.
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/mul_core.sv
// 32x32 signed/unsigned multiplier with a LAT-stage output pipeline.
// The product of the current a/b/uns appears on p LAT cycles later.
module mul_core
  import mul_arb_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        uns,
  output logic [63:0] p
);

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [63:0] pipe_q [LAT];

  // Extend both operands to 64 bits; the low 64 bits of the product are then exact.
  always_comb begin
    ext_a = {{32{~uns & a[31]}}, a};
    ext_b = {{32{~uns & b[31]}}, b};
    prod  = ext_a * ext_b;
  end

  // Output pipeline: stage 0 captures the product, later stages shift it along.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= prod;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p = pipe_q[LAT-1];

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of a shared pipelined multiplier.
// Ties go to requester 0 unless MUL_ARB_ROUND_ROBIN_EN is defined, in which
// case they alternate via a round-robin pointer.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  u,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  output logic [1:0]  stall,
  output logic [1:0]  done,
  output logic [63:0] z,
  output logic        busy
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               grant_q;
  logic [1:0]         done_q;
  logic [63:0]        z_q;
  logic               busy_q;
  logic [31:0]        x_q, y_q;
  logic               u_q;
  logic [31:0]        x_d, y_d;
  logic               u_d;
  logic               win;
  logic               take;
  logic [63:0]        core_p;

`ifdef MUL_ARB_ROUND_ROBIN_EN
  logic               rr_q;

  // Tie goes to the pointer; a lone request always wins.
  always_comb begin
    win = (req == 2'b11) ? rr_q : req[1];
  end

  // Pointer moves to the requester that did not just win, only on a grant.
  always_ff @(posedge clk) begin
    if (rst)       rr_q <= 1'b0;
    else if (take) rr_q <= ~win;
  end
`else
  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    win = ~req[0];
  end
`endif

  // Select the winner's operands on a grant, otherwise hold the latched ones.
  always_comb begin
    take = (state_q == IDLE) && (req != 2'b00);
    x_d  = x_q;
    y_d  = y_q;
    u_d  = u_q;
    if (take) begin
      x_d = win ? x1 : x0;
      y_d = win ? y1 : y0;
      u_d = win ? u[1] : u[0];
    end
  end

  // Operand latch so later input changes cannot disturb the in-flight product.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      u_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      u_q <= u_d;
    end
  end

  // Core sees the next-state operands so its first stage fills on the grant edge.
  mul_core #(
    .LAT (LAT)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .a   (x_d),
    .b   (y_d),
    .uns (u_d),
    .p   (core_p)
  );

  // Control FSM with registered done/z/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      done_q  <= 2'b00;
      z_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            grant_q <= win;
            cnt_q   <= CNT_W'(LAT);
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_q   <= '0;
            z_q     <= core_p;
            done_q  <= grant_q ? 2'b10 : 2'b01;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done  = done_q;
  assign z     = z_q;
  assign busy  = busy_q;
  assign stall = req & ~done_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: three instances (LAT = 1, 3, 4) share one stimulus.
// A timeline model predicts done/busy/z/stall for every cycle; directed
// literal checks pin the model to hand-computed values.
// Honours MUL_ARB_ROUND_ROBIN_EN for the tie-break expectations.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, u;
  logic [31:0] x0, y0, x1, y1;

  logic [1:0]  stall_w [3];
  logic [1:0]  done_w  [3];
  logic [63:0] z_w     [3];
  logic        busy_w  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mul_arbiter #(
      .LAT (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .u     (u),
      .x0    (x0),
      .y0    (y0),
      .x1    (x1),
      .y1    (y1),
      .stall (stall_w[g]),
      .done  (done_w[g]),
      .z     (z_w[g]),
      .busy  (busy_w[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic uns);
    logic [63:0] ea, eb;
    if (uns) begin
      ea = {32'h0, a};
      eb = {32'h0, b};
    end else begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end
    return ea * eb;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Timeline model: an accepted request at edge t completes at edge t+LAT,
  // the instance is occupied through edge t+LAT+1 and can accept again after.
  bit          m_act [3];
  int          m_ts  [3];
  bit          m_w   [3];
  bit          m_rr  [3];
  logic [63:0] m_p   [3];
  logic [63:0] m_z   [3];
  logic [1:0]  m_d   [3];
  int          edge_n = 0;
  int          ord0[$], ord1[$], ord2[$];

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_act[k] = 1'b0;
        m_rr[k]  = 1'b0;
        m_z[k]   = '0;
        m_d[k]   = 2'b00;
      end else if (m_act[k]) begin
        if (edge_n == m_ts[k] + lat_of(k)) begin
          m_z[k] = m_p[k];
          m_d[k] = m_w[k] ? 2'b10 : 2'b01;
        end else if (edge_n == m_ts[k] + lat_of(k) + 1) begin
          m_act[k] = 1'b0;
          m_d[k]   = 2'b00;
        end
      end else if (req != 2'b00) begin
        if (req == 2'b01)      m_w[k] = 1'b0;
        else if (req == 2'b10) m_w[k] = 1'b1;
        else begin
`ifdef MUL_ARB_ROUND_ROBIN_EN
          m_w[k] = m_rr[k];
`else
          m_w[k] = 1'b0;
`endif
        end
        m_rr[k]  = ~m_w[k];
        m_p[k]   = m_w[k] ? ref_mul(x1, y1, u[1]) : ref_mul(x0, y0, u[0]);
        m_ts[k]  = edge_n;
        m_act[k] = 1'b1;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model dut%0d done", k), {62'h0, done_w[k]}, {62'h0, m_d[k]});
      chk($sformatf("model dut%0d busy", k), {63'h0, busy_w[k]}, {63'h0, m_act[k]});
      chk($sformatf("model dut%0d z", k), z_w[k], m_z[k]);
      chk($sformatf("model dut%0d stall", k), {62'h0, stall_w[k]},
          {62'h0, req & ~m_d[k]});
      if (done_w[k] != 2'b00) begin
        case (k)
          0:       ord0.push_back(int'(done_w[k][1]));
          1:       ord1.push_back(int'(done_w[k][1]));
          default: ord2.push_back(int'(done_w[k][1]));
        endcase
      end
    end
  end

  task automatic nclk(input int c);
    repeat (c) @(negedge clk);
  endtask

  int exp_ord [4];

  initial begin
    rst = 1'b1; req = 2'b00; u = 2'b00;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    nclk(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset dut%0d busy", k), {63'h0, busy_w[k]}, 64'h0);
      chk($sformatf("reset dut%0d done", k), {62'h0, done_w[k]}, 64'h0);
      chk($sformatf("reset dut%0d z", k), z_w[k], 64'h0);
    end
    rst = 1'b0;
    nclk(2);

    // Requester 0 alone, signed -1 * 2; request held until its done (LAT=1).
    u = 2'b00; x0 = 32'hFFFF_FFFF; y0 = 32'd2; req = 2'b01;
    nclk(1);
    chk("A stall0 cycle1", {62'h0, stall_w[0]}, 64'h1);
    chk("A done0 early", {62'h0, done_w[0]}, 64'h0);
    nclk(1);
    chk("A done0", {62'h0, done_w[0]}, 64'h1);
    chk("A z0", z_w[0], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("A stall0 released", {62'h0, stall_w[0]}, 64'h0);
    req = 2'b00;
    nclk(2);
    chk("A lat4 done not yet", {62'h0, done_w[2]}, 64'h0);
    chk("A lat4 busy", {63'h0, busy_w[2]}, 64'h1);
    nclk(1);
    chk("A lat4 done", {62'h0, done_w[2]}, 64'h1);
    chk("A lat4 z", z_w[2], 64'hFFFF_FFFF_FFFF_FFFE);
    nclk(1);
    chk("A lat4 busy off", {63'h0, busy_w[2]}, 64'h0);
    nclk(2);

    // Requester 1 alone, unsigned max*max; request dropped after one cycle.
    u = 2'b10; x1 = 32'hFFFF_FFFF; y1 = 32'hFFFF_FFFF; req = 2'b10;
    nclk(1);
    req = 2'b00; x1 = '0;
    nclk(1);
    chk("B done1", {62'h0, done_w[0]}, 64'h2);
    chk("B z", z_w[0], 64'hFFFF_FFFE_0000_0001);
    nclk(5);
    chk("B lat4 z", z_w[2], 64'hFFFF_FFFE_0000_0001);
    nclk(1);

    // Signed 7 * -3 with operands and sign mode scrambled after the grant.
    u = 2'b00; x0 = 32'd7; y0 = 32'hFFFF_FFFD; req = 2'b01;
    nclk(1);
    x0 = '0; y0 = '0; u = 2'b11; req = 2'b00;
    nclk(4);
    chk("C lat4 done", {62'h0, done_w[2]}, 64'h1);
    chk("C lat4 z", z_w[2], 64'hFFFF_FFFF_FFFF_FFEB);
    chk("C lat1 z", z_w[0], 64'hFFFF_FFFF_FFFF_FFEB);
    nclk(2);

    // Both requesters held high: tie-break order.
    ord0.delete(); ord1.delete(); ord2.delete();
    u = 2'b00; x0 = 32'd3; y0 = 32'd5; x1 = 32'd11; y1 = 32'd13; req = 2'b11;
    nclk(14);
    req = 2'b00;
    nclk(8);
`ifdef MUL_ARB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    chk("D lat1 count", 64'(ord0.size()), 64'd5);
    chk("D lat3 count", 64'(ord1.size()), 64'd3);
    chk("D lat4 count", 64'(ord2.size()), 64'd3);
    for (int i = 0; i < 4; i++)
      if (i < ord0.size()) chk($sformatf("D lat1 grant%0d", i), 64'(ord0[i]), 64'(exp_ord[i]));
    for (int i = 0; i < 3; i++) begin
      if (i < ord1.size()) chk($sformatf("D lat3 grant%0d", i), 64'(ord1[i]), 64'(exp_ord[i]));
      if (i < ord2.size()) chk($sformatf("D lat4 grant%0d", i), 64'(ord2[i]), 64'(exp_ord[i]));
    end

    // Reset while the LAT=3 instance is busy, then a tie right after reset.
    u = 2'b00; x0 = 32'd5; y0 = 32'd6; req = 2'b01;
    nclk(1);
    req = 2'b00;
    nclk(1);
    chk("E lat3 busy before rst", {63'h0, busy_w[1]}, 64'h1);
    rst = 1'b1;
    nclk(1);
    rst = 1'b0;
    chk("E lat3 busy after rst", {63'h0, busy_w[1]}, 64'h0);
    chk("E lat3 z after rst", z_w[1], 64'h0);
    chk("E lat3 done after rst", {62'h0, done_w[1]}, 64'h0);
    x1 = 32'd2; y1 = 32'd2; req = 2'b11;
    #1;
    chk("E stall after rst", {62'h0, stall_w[1]}, 64'h3);
    nclk(1);
    req = 2'b00;
    nclk(3);
    chk("E lat3 fresh done", {62'h0, done_w[1]}, 64'h1);
    chk("E lat3 fresh z", z_w[1], 64'd30);
    nclk(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
